// File: rtl/alu_4bit_if.sv
// alu_4bit_if: operand/result bundle between a requester and the registered logic unit
interface alu_4bit_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             zero;
  modport master (output in_valid, a, b, sel, input y, out_valid, zero);
  modport slave  (input in_valid, a, b, sel, output y, out_valid, zero);
endinterface

// File: rtl/alu_4bit.sv
// alu_4bit: registered bitwise AND/OR/XOR/NOT unit with valid and zero flags
module alu_4bit #(
  parameter int WIDTH = 4
) (
  input logic       clk,
  input logic       rst_n,
  alu_4bit_if.slave bus
);
  logic [WIDTH-1:0] f;
  // selected bitwise function; b is ignored for NOT
  always_comb
    f = bus.sel == 2'b00 ? bus.a & bus.b :
        bus.sel == 2'b01 ? bus.a | bus.b :
        bus.sel == 2'b10 ? bus.a ^ bus.b : ~bus.a;
  // result and zero flag load only on accepted ops; valid follows in_valid each edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.y         <= '0;
      bus.zero      <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.y    <= f;
        bus.zero <= ~|f;
      end
    end
endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: directed plus randomized checks of alu_4bit against a per-bit truth-table model
module tb_alu_4bit;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [3:0] ey;
  logic       ez;
  logic       ev;

  alu_4bit_if #(.WIDTH(4)) bus();
  alu_4bit #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] ref_f(input logic [3:0] ra, input logic [3:0] rb, input logic [1:0] rs);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      case (rs)
        2'd0: r[i] = ra[i] && rb[i];
        2'd1: r[i] = ra[i] || rb[i];
        2'd2: r[i] = ra[i] != rb[i];
        default: r[i] = !ra[i];
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y"}, bus.y, ey);
    check({tag, ".zero"}, {3'b0, bus.zero}, {3'b0, ez});
    check({tag, ".valid"}, {3'b0, bus.out_valid}, {3'b0, ev});
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] ta, input logic [3:0] tb, input logic [1:0] ts);
    bus.in_valid = v;
    bus.a = ta;
    bus.b = tb;
    bus.sel = ts;
    @(posedge clk);
    if (v) begin
      ey = ref_f(ta, tb, ts);
      ez = (ey == 4'd0);
    end
    ev = v;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    ey = 4'd0;
    ez = 1'b1;
    ev = 1'b0;
    #1 check_all(tag);
    @(negedge clk);
    check_all({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 4'($urandom);
    bus.b = 4'($urandom);
    bus.sel = 2'($urandom);
    #2 rst_n = 1'b0;
    ey = 4'd0;
    ez = 1'b1;
    ev = 1'b0;
    #1 check_all("reset_async");
    @(negedge clk);
    check_all("reset_clocked");
    rst_n = 1'b1;
    step("and", 1'b1, 4'b1100, 4'b1010, 2'b00);
    check("and_lit", bus.y, 4'b1000);
    step("or", 1'b1, 4'b1100, 4'b1010, 2'b01);
    check("or_lit", bus.y, 4'b1110);
    step("xor", 1'b1, 4'b1100, 4'b1010, 2'b10);
    check("xor_lit", bus.y, 4'b0110);
    step("xor_zero", 1'b1, 4'b0101, 4'b0101, 2'b10);
    check("xor_zero_flag", {3'b0, bus.zero}, 4'd1);
    for (int i = 0; i < 16; i++) begin
      step("not_sweep", 1'b1, 4'b0011, 4'(i), 2'b11);
      check("not_lit", bus.y, 4'b1100);
    end
    step("not_zero", 1'b1, 4'b1111, 4'b0110, 2'b11);
    check("not_zero_flag", {3'b0, bus.zero}, 4'd1);
    step("hold_load", 1'b1, 4'b1111, 4'b0001, 2'b00);
    check("hold_load_lit", bus.y, 4'b0001);
    step("hold", 1'b0, 4'b0110, 4'b1001, 2'b01);
    check("hold_lit", bus.y, 4'b0001);
    step("hold2", 1'b0, 4'b0000, 4'b0000, 2'b11);
    step("zero_load", 1'b1, 4'b1010, 4'b0101, 2'b00);
    step("zero_hold", 1'b0, 4'b1111, 4'b1111, 2'b01);
    for (int s = 0; s < 4; s++)
      for (int x = 0; x < 16; x++)
        for (int z = 0; z < 16; z++) begin
          step("sweep", 1'b1, 4'(x), 4'(z), 2'(s));
          if (s == 2 && x == 7 && z == 3) mid_reset("sweep_reset");
        end
    for (int i = 0; i < 300; i++) begin
      step("random", 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 2'($urandom));
      if (i == 150) mid_reset("random_reset");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
